alu_32_bit: RTL and testbench

Registered 32-bit integer ALU for the MIPS datapath execute stage. It computes AND, OR, ADD, SUB, SLT and NOR on two 32-bit signed operands, selected by a 4-bit MIPS-style ALU control code. Result and zero flag are registered, with one-cycle latency. The zero flag feeds branch-equal decision logic.

---
 rtl/alu_32_bit.sv | 61 ++++++
 tb/tb_alu_32_bit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_32_bit.sv
// Registered MIPS execute-stage ALU (AND/OR/ADD/SUB/SLT/NOR) with zero flag.
// Latency 1 cycle, captures every edge; no backpressure, no enable.
module alu_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic             less;
    logic [WIDTH-1:0] result_next;

    // One shared adder: subtraction is a + ~b + 1, also used by SLT.
    assign sub_mode = (alu_code == OP_SUB) || (alu_code == OP_SLT);
    assign b_eff    = sub_mode ? ~b : b;
    assign sum      = a + b_eff + {{(WIDTH-1){1'b0}}, sub_mode};

    // Signed less-than stays correct when a - b overflows.
    assign ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign less = sum[WIDTH-1] ^ ovf;

    always_comb begin
        result_next = '0;
        case (alu_code)
            OP_AND:  result_next = a & b;
            OP_OR:   result_next = a | b;
            OP_ADD:  result_next = sum;
            OP_SUB:  result_next = sum;
            OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, less};
            OP_NOR:  result_next = ~(a | b);
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= result_next;
            zero   <= (result_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_32_bit.sv
// Directed and randomized checks of alu_32_bit against an arithmetic reference model.
module tb_alu_32_bit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    alu_32_bit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_code (alu_code),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] code,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (code)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return 32'(sx + sy);
            4'd6:  return 32'(sx - sy);
            4'd7:  return (sx < sy) ? 32'd1 : 32'd0;
            4'd12: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] er, input logic ez);
        total++;
        assert (result === er) else begin
            bad++;
            $error("FAIL %s result=%h expected=%h", tag, result, er);
        end
        total++;
        assert (zero === ez) else begin
            bad++;
            $error("FAIL %s zero=%b expected=%b", tag, zero, ez);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] code,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er);
        @(negedge clk);
        alu_code = code;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        check(tag, er, er == 32'd0);
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        logic [3:0]  codes [8];
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd3};

        rst_n    = 1'b0;
        alu_code = 4'b0010;
        a        = 32'd7;
        b        = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'd0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 32'd13, 1'b0);

        step("add_5_6",     4'b0010, 32'd5, 32'd6, 32'd11);
        step("sub_7_6",     4'b0110, 32'd7, 32'd6, 32'd1);
        step("sub_m7_6",    4'b0110, -32'sd7, 32'd6, 32'hFFFFFFF3);
        step("sub_m7_m6",   4'b0110, -32'sd7, -32'sd6, 32'hFFFFFFFF);
        step("sub_6_7",     4'b0110, 32'd6, 32'd7, 32'hFFFFFFFF);
        step("sub_7_7",     4'b0110, 32'd7, 32'd7, 32'd0);

        step("slt_7_6",     4'b0111, 32'd7, 32'd6, 32'd0);
        step("slt_m7_6",    4'b0111, -32'sd7, 32'd6, 32'd1);
        step("slt_m7_m6",   4'b0111, -32'sd7, -32'sd6, 32'd1);
        step("slt_6_7",     4'b0111, 32'd6, 32'd7, 32'd1);
        step("slt_m6_m7",   4'b0111, -32'sd6, -32'sd7, 32'd0);
        step("slt_7_7",     4'b0111, 32'd7, 32'd7, 32'd0);
        step("slt_min_1",   4'b0111, 32'h80000000, 32'd1, 32'd1);
        step("slt_max_m1",  4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0);

        step("and",         4'b0000, 32'h4F, 32'h7F, 32'h0000004F);
        step("or",          4'b0001, 32'h4F, 32'h7F, 32'h0000007F);
        step("nor",         4'b1100, 32'h4F, 32'h7F, 32'hFFFFFF80);

        step("add_wrap",    4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000);
        step("sub_wrap",    4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF);

        // Inputs changed between edges must not reach the outputs early.
        step("pre_change",  4'b0010, 32'd100, 32'd23, 32'd123);
        alu_code = 4'b0110;
        a        = 32'd9;
        b        = 32'd9;
        #3;
        check("mid_cycle_hold", 32'd123, 1'b0);
        @(posedge clk);
        #1;
        check("mid_cycle_next", 32'd0, 1'b1);

        step("undef_1111",  4'b1111, 32'd5, 32'd5, 32'd0);

        step("pre_reset",   4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A55A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            rc = codes[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       ra = 32'h80000000;
                1:       ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 32'($urandom_range(0, 3)) - 32'd1;
                default: rb = $urandom;
            endcase
            step("random", rc, ra, rb, ref_alu(rc, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
